rvx_bus_memory_responder: RTL

Responder (memory side) for the RVX instruction/data bus. It accepts read and write requests from a core bus controller and serves them from an internal word-organised memory. Responses can be delayed by a programmable number of wait states, which stretches the core's clock_enable stall. It is used as on-chip RAM and as a latency-injecting test target for core bring-up and regression.

---
 rtl/rvx_bus_memory_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rvx_bus_memory_responder.sv
// -----------------------------------------------------------------------------
// rvx_bus_memory_responder
//
// Memory-side responder for the RVX instruction/data bus. It serves read and
// write requests from an internal word-organised RAM. A programmable number of
// wait states can be inserted between request capture and response, which lets
// the block act as a latency-injecting target during core bring-up.
//
// Parameters:
//   MEMORY_SIZE_BYTES  capacity in bytes (power of two, >= 8)
//   WAIT_STATES        idle cycles between capture and response (0..15)
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous active-high reset (memory contents kept)
//   address         byte address; bits [1:0] ignored, high bits alias
//   rrequest        read request
//   wrequest        write request
//   wdata           write data, little-endian byte lanes
//   wstrobe         byte-lane write enables
//   rdata           read data, valid while rresponse=1, held otherwise
//   rresponse       one-cycle read completion
//   wresponse       one-cycle write completion
//   protocol_error  sticky: read and write requested together
// -----------------------------------------------------------------------------
module rvx_bus_memory_responder #(
  parameter int MEMORY_SIZE_BYTES = 8192,
  parameter int WAIT_STATES       = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rrequest,
  input  logic        wrequest,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrobe,
  output logic [31:0] rdata,
  output logic        rresponse,
  output logic        wresponse,
  output logic        protocol_error
);

  localparam int         WORDS      = MEMORY_SIZE_BYTES / 4;
  localparam int         INDEX_W    = $clog2(MEMORY_SIZE_BYTES) - 2;
  localparam logic [3:0] WAIT_COUNT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT    = (WAIT_STATES == 0);

  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
    $error("rvx_bus_memory_responder: WAIT_STATES must be in 0..15");
  end

  if ((MEMORY_SIZE_BYTES < 8) ||
      ((MEMORY_SIZE_BYTES & (MEMORY_SIZE_BYTES - 1)) != 0)) begin : g_bad_size
    $error("rvx_bus_memory_responder: MEMORY_SIZE_BYTES must be a power of two >= 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         count;
  logic [INDEX_W-1:0] cap_index;
  logic               cap_write;
  logic [31:0]        cap_wdata;
  logic [3:0]         cap_wstrobe;

  logic [31:0] mem [0:WORDS-1];

  logic               capture;
  logic               enter_resp;
  logic               acc_write;
  logic [INDEX_W-1:0] acc_index;
  logic [31:0]        acc_wdata;
  logic [3:0]         acc_wstrobe;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_address_bits;
  assign unused_address_bits = ^{address[31:INDEX_W+2], address[1:0]};

  // Decide whether the next edge enters RESP and which transaction it serves.
  // With no wait states the live request is served directly; after a wait the
  // captured copy is used because the inputs are not looked at in WAIT.
  always_comb begin
    capture     = ((state == ST_IDLE) || (state == ST_RESP)) && (rrequest || wrequest);
    enter_resp  = 1'b0;
    acc_write   = 1'b0;
    acc_index   = '0;
    acc_wdata   = 32'd0;
    acc_wstrobe = 4'd0;
    if (state == ST_WAIT) begin
      enter_resp  = (count == 4'd0);
      acc_write   = cap_write;
      acc_index   = cap_index;
      acc_wdata   = cap_wdata;
      acc_wstrobe = cap_wstrobe;
    end else begin
      enter_resp  = capture && NO_WAIT;
      acc_write   = wrequest;   // write wins when both are requested
      acc_index   = address[INDEX_W+1:2];
      acc_wdata   = wdata;
      acc_wstrobe = wstrobe;
    end
  end

  // Memory array: byte-lane write on the edge that enters RESP; never reset.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && acc_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrobe[i]) begin
          mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      count          <= 4'd0;
      cap_index      <= '0;
      cap_write      <= 1'b0;
      cap_wdata      <= 32'd0;
      cap_wstrobe    <= 4'd0;
      rdata          <= 32'd0;
      rresponse      <= 1'b0;
      wresponse      <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      rresponse <= 1'b0;
      wresponse <= 1'b0;

      if (capture) begin
        cap_index   <= address[INDEX_W+1:2];
        cap_write   <= wrequest;
        cap_wdata   <= wdata;
        cap_wstrobe <= wstrobe;
        if (rrequest && wrequest) begin
          protocol_error <= 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_RESP: begin
          if (capture) begin
            if (NO_WAIT) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              count <= WAIT_COUNT - 4'd1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (count == 4'd0) begin
            state <= ST_RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 4'd0;
        end
      endcase

      if (enter_resp) begin
        if (acc_write) begin
          wresponse <= 1'b1;
        end else begin
          rresponse <= 1'b1;
          rdata     <= mem[acc_index];
        end
      end
    end
  end

endmodule
